// File: rtl/bcd_adder_serial.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// done pulses DIGITS+1 cycles after start (invalid operands: next cycle); start is ignored while busy.
module bcd_adder_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op_sub,
  input  logic                cin,
  input  logic [4*DIGITS-1:0] x,
  input  logic [4*DIGITS-1:0] y,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                error
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    y_q, y_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            sub_q, sub_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            bad_digit;
  logic [3:0]      b_dig;
  logic [4:0]      t;
  logic [3:0]      dig;
  logic            cy;
  logic            last;
  logic [W-1:0]    acc_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    sub_d     = sub_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    done_d    = 1'b0;
    error_d   = error_q;
    bad_digit = 1'b0;
    acc_shift = '0;

    for (int i = 0; i < DIGITS; i++) begin
      if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end

    // Operands shift right each RUN cycle, so the current digit is always at [3:0].
    b_dig = sub_q ? (4'd9 - y_q[3:0]) : y_q[3:0];
    t     = {1'b0, x_q[3:0]} + {1'b0, b_dig} + {4'd0, carry_q};
    if (t > 5'd9) begin
      dig = t[3:0] + 4'd6;
      cy  = 1'b1;
    end else begin
      dig = t[3:0];
      cy  = 1'b0;
    end

    // New digit enters at the top; after DIGITS shifts digit 0 sits at [3:0].
    for (int i = 0; i < DIGITS - 1; i++) begin
      acc_shift[4*i +: 4] = acc_q[4*(i+1) +: 4];
    end
    acc_shift[4*(DIGITS-1) +: 4] = dig;

    last = (idx_q == IW'(DIGITS - 1));

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d   = x;
          y_d   = y;
          sub_d = op_sub;
          if (bad_digit) begin
            error_d = 1'b1;
            sum_d   = '0;
            cout_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            idx_d   = '0;
            acc_d   = '0;
            error_d = 1'b0;
            carry_d = op_sub ? ~cin : cin;
          end
        end
      end
      RUN: begin
        acc_d   = acc_shift;
        carry_d = cy;
        x_d     = x_q >> 4;
        y_d     = y_q >> 4;
        idx_d   = idx_q + IW'(1);
        if (last) begin
          sum_d   = acc_shift;
          cout_d  = cy;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign error = error_q;

endmodule

// File: tb/tb_bcd_adder_serial.sv
// Scoreboard bench for bcd_adder_serial with DIGITS=4: directed vectors plus random ops.
module tb_bcd_adder_serial;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         busy, done, cout, error;
  logic [W-1:0] sum;

  bcd_adder_serial #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .cin(cin),
    .x(x), .y(y), .busy(busy), .done(done), .sum(sum), .cout(cout), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         e;
    int           due;
  } exp_t;

  exp_t         sbq[$];
  int           n_vec = 0;
  int           n_bad = 0;
  int           cyc = 0;
  logic [W-1:0] prev_sum = '0;
  logic         last_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic c);
    exp_t e;
    int r;
    int lim = 10 ** D;
    logic bad = 1'b0;
    for (int i = 0; i < D; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
    e.e = bad;
    e.due = 0;
    if (bad) begin
      e.s = '0;
      e.c = 1'b0;
    end else if (!sub) begin
      r = bcd2int(a) + bcd2int(b) + int'(c);
      e.c = (r >= lim);
      e.s = int2bcd(r % lim);
    end else begin
      r = bcd2int(a) - bcd2int(b) - int'(c);
      e.c = (r >= 0);
      e.s = int2bcd(r < 0 ? r + lim : r);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) check("sum_hold_run", sum, prev_sum);
      if (done && last_done) check("done_width", 1, 0);
      if (done) begin
        if (sbq.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("sum", sum, e.s);
          check("cout", cout, e.c);
          check("error", error, e.e);
          check("done_cycle", cyc, e.due);
          prev_sum = e.s;
        end
      end
    end
    last_done = done;
  end

  task automatic push_exp(input logic [W-1:0] s, input logic c, input logic e);
    exp_t ex;
    ex.s = s;
    ex.c = c;
    ex.e = e;
    ex.due = cyc + (e ? 0 : D);
    sbq.push_back(ex);
  endtask

  task automatic scramble();
    x = W'($urandom);
    y = W'($urandom);
    op_sub = 1'($urandom);
    cin = 1'($urandom);
  endtask

  // Drives one start pulse; returns at the negedge following the accepting edge.
  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic sa,
                       input logic ca, input logic [W-1:0] es, input logic ec,
                       input logic ee, input bit track);
    @(negedge clk);
    x = xa; y = ya; op_sub = sa; cin = ca; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (track) push_exp(es, ec, ee);
    scramble();
    @(negedge clk);
    check("busy_after_start", busy, !ee);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      check("timeout_waiting_done", 0, 1);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic sub, c;
    logic [W-1:0] s;
    logic co, e;
  } vec_t;

  vec_t dir[8];

  initial begin
    dir[0] = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0};
    dir[1] = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    dir[2] = '{16'h9999, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0};
    dir[3] = '{16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b1, 1'b0};
    dir[4] = '{16'h1234, 16'h5000, 1'b1, 1'b0, 16'h6234, 1'b0, 1'b0};
    dir[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0};
    dir[6] = '{16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    dir[7] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_error", error, 0);

    foreach (dir[i]) begin
      issue(dir[i].a, dir[i].b, dir[i].sub, dir[i].c, dir[i].s, dir[i].co, dir[i].e, 1'b1);
      wait_idle();
    end

    // A second start during RUN must not disturb the operation in flight.
    issue(16'h0456, 16'h0789, 1'b0, 1'b0, 16'h1245, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    x = 16'h9999; y = 16'h9999; op_sub = 1'b1; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    // Reset mid-operation: no done, outputs cleared.
    issue(16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    prev_sum = '0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    repeat (D + 3) @(negedge clk);

    // start held across done: second op accepted with no bubble.
    @(negedge clk);
    x = 16'h2500; y = 16'h2500; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    push_exp(16'h5000, 1'b0, 1'b0);
    x = 16'h0100; y = 16'h0250; op_sub = 1'b1; cin = 1'b0;
    repeat (D + 1) @(posedge clk);
    #1;
    start = 1'b0;
    push_exp(16'h9850, 1'b0, 1'b0);
    scramble();
    wait_idle();

    for (int n = 0; n < 14; n++) begin
      logic [W-1:0] a, b;
      logic s, c;
      exp_t e;
      for (int i = 0; i < D; i++) begin
        a[4*i +: 4] = 4'($urandom_range(0, 9));
        b[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) a[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      s = 1'($urandom);
      c = 1'($urandom);
      e = model(a, b, s, c);
      issue(a, b, s, c, e.s, e.c, e.e, 1'b1);
      wait_idle();
    end

    check("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
    $fatal(1);
  end

endmodule
